// File: rtl/btb_pkg.sv
// Shared types, sizes and field helpers for the two-way branch target buffer.
// Latency: n/a (package only).
// Backpressure: n/a.
package btb_pkg;

  localparam int PC_W     = 32;
  localparam int NUM_SETS = 8;
  localparam int IDX_W    = 3;
  localparam int TAG_W    = PC_W - IDX_W - 2;

  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] CTR_MAX        = 2'b11;
  localparam logic [1:0] CTR_MIN        = 2'b00;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [1:0]       ctr;
  } btb_entry_t;

  // Set index: word-aligned PC bits just above the byte offset.
  function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  // Tag: every PC bit above the set index.
  function automatic logic [TAG_W-1:0] tag_of(input logic [PC_W-1:0] pc);
    return pc[PC_W-1:IDX_W+2];
  endfunction

endpackage

// File: rtl/btb_set_assoc_lru_next.sv
// Next-state logic for the per-set LRU vector (one bit per set, names the way to replace next).
// Latency: combinational.
// Backpressure: none; write-side request overrides a read-side request to the same set.
module lru_next
  import btb_pkg::*;
(
  input  logic [NUM_SETS-1:0] lru,
  input  logic                rd_valid,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic                update_lru_read,
  input  logic                wr_valid,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                update_lru_write,
  output logic [NUM_SETS-1:0] lru_nxt
);

  // Apply the lookup-side touch first so a training write to the same set lands last.
  always_comb begin
    lru_nxt = lru;
    if (rd_valid) lru_nxt[rd_idx] = update_lru_read;
    if (wr_valid) lru_nxt[wr_idx] = update_lru_write;
  end

endmodule

// File: rtl/btb_set_assoc.sv
// Two-way, 8-set branch target buffer: combinational fetch lookup, execute-side training.
// Latency: lookup 0 cycles; updates visible the cycle after the training edge (no bypass).
// Backpressure: none; every update is absorbed at the edge it is presented.
module btb_set_assoc
  import btb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_hit,
  output logic            predict_taken,
  output logic [PC_W-1:0] predict_target,
  input  logic            update_valid,
  input  logic [PC_W-1:0] update_pc,
  input  logic [PC_W-1:0] update_target,
  input  logic            update_taken
);

  btb_entry_t          mem [NUM_SETS][2];
  logic [NUM_SETS-1:0] lru;
  logic [NUM_SETS-1:0] lru_nxt;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit0, l_hit1, l_way;
  logic             u_hit0, u_hit1, u_hit, u_way;
  logic             victim;
  logic [1:0]       ctr_upd;
  logic             lru_rd_en, lru_wr_en, lru_wr_val;
  btb_entry_t       l_ent, u_ent;
  logic             unused_pc_lsbs;

  // Byte-offset bits never reach the tables.
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  assign l_idx = idx_of(lookup_pc);
  assign l_tag = tag_of(lookup_pc);
  assign u_idx = idx_of(update_pc);
  assign u_tag = tag_of(update_pc);

  // Fetch-side lookup; way0 wins if both ways ever match.
  always_comb begin
    l_hit0         = mem[l_idx][0].valid && (mem[l_idx][0].tag == l_tag);
    l_hit1         = mem[l_idx][1].valid && (mem[l_idx][1].tag == l_tag);
    l_way          = !l_hit0;
    l_ent          = mem[l_idx][l_way];
    lookup_hit     = l_hit0 || l_hit1;
    predict_taken  = lookup_hit && l_ent.ctr[1];
    predict_target = lookup_hit ? l_ent.target : '0;
  end

  // Training-side match, victim choice and saturating counter step.
  always_comb begin
    u_hit0 = mem[u_idx][0].valid && (mem[u_idx][0].tag == u_tag);
    u_hit1 = mem[u_idx][1].valid && (mem[u_idx][1].tag == u_tag);
    u_hit  = u_hit0 || u_hit1;
    u_way  = !u_hit0;
    u_ent  = mem[u_idx][u_way];
    if (!mem[u_idx][0].valid)      victim = 1'b0;
    else if (!mem[u_idx][1].valid) victim = 1'b1;
    else                           victim = lru[u_idx];
    if (update_taken) ctr_upd = (u_ent.ctr == CTR_MAX) ? CTR_MAX : u_ent.ctr + 2'd1;
    else              ctr_upd = (u_ent.ctr == CTR_MIN) ? CTR_MIN : u_ent.ctr - 2'd1;
  end

  // LRU requests: a miss that is not taken leaves the set alone; a same-set update masks the lookup touch.
  always_comb begin
    lru_wr_en  = update_valid && (u_hit || update_taken);
    lru_wr_val = u_hit ? !u_way : !victim;
    lru_rd_en  = lookup_hit && !(update_valid && (u_idx == l_idx));
  end

  lru_next u_lru_next (
    .lru              (lru),
    .rd_valid         (lru_rd_en),
    .rd_idx           (l_idx),
    .update_lru_read  (!l_way),
    .wr_valid         (lru_wr_en),
    .wr_idx           (u_idx),
    .update_lru_write (lru_wr_val),
    .lru_nxt          (lru_nxt)
  );

  // Storage and LRU state: reset beats flush, flush beats training.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lru <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < 2; w++) begin
          mem[s][w].valid <= 1'b0;
          mem[s][w].ctr   <= CTR_MIN;
        end
      end
    end else if (flush) begin
      lru <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < 2; w++) begin
          mem[s][w].valid <= 1'b0;
        end
      end
    end else begin
      lru <= lru_nxt;
      if (update_valid) begin
        if (u_hit) begin
          mem[u_idx][u_way].ctr <= ctr_upd;
          if (update_taken) mem[u_idx][u_way].target <= update_target;
        end else if (update_taken) begin
          mem[u_idx][victim].valid  <= 1'b1;
          mem[u_idx][victim].tag    <= u_tag;
          mem[u_idx][victim].target <= update_target;
          mem[u_idx][victim].ctr    <= CTR_WEAK_TAKEN;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
module tb_btb_set_assoc;

  localparam logic [31:0] IDLE_PC = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic        tk;
    logic [31:0] tg;
  } lk_t;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [31:0] lookup_pc;
  logic        lookup_hit, predict_taken;
  logic [31:0] predict_target;
  logic        update_valid, update_taken;
  logic [31:0] update_pc, update_target;

  lk_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  btb_set_assoc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .lookup_pc      (lookup_pc),
    .lookup_hit     (lookup_hit),
    .predict_taken  (predict_taken),
    .predict_target (predict_target),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_target  (update_target),
    .update_taken   (update_taken)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (no checking): all called in the negedge phase.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input logic tk);
    update_valid = 1'b1; update_pc = pc; update_target = tg; update_taken = tk;
    @(negedge clk);
    update_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drive_lookup(input lk_t e);
    sb.push_back(e);
    lookup_pc = e.pc;
  endtask

  task automatic test_reset();
    lk_t e;
    rst_n = 1'b0;
    update_valid = 1'b1; update_pc = 32'h1000; update_target = 32'h2000; update_taken = 1'b1;
    repeat (2) @(negedge clk);
    update_valid = 1'b0;
    rst_n = 1'b1;
    drive_lookup({32'h1000, 1'b0, 1'b0, 32'h0});
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({lookup_hit, predict_taken, predict_target} !== {e.hit, e.tk, e.tg}) begin
      n_bad++;
      $display("FAIL reset pc=%h got %b/%b/%h want %b/%b/%h", e.pc, lookup_hit, predict_taken, predict_target, e.hit, e.tk, e.tg);
    end
    lookup_pc = IDLE_PC;
    @(negedge clk);
  endtask

  task automatic test_counter();
    lk_t         e;
    logic        tk_s   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        exp_tk [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_tg [9] = '{32'h2000, 32'h2000, 32'h2000, 32'h2400, 32'h2400,
                                32'h2400, 32'h2400, 32'h2400, 32'h2400};
    upd(32'h1000, 32'h2000, 1'b1);
    for (int i = -1; i < 9; i++) begin
      if (i >= 0) upd(32'h1000, tk_s[i] ? 32'h2400 : 32'hDEAD_0000, tk_s[i]);
      drive_lookup({32'h1000, 1'b1, (i < 0) ? 1'b1 : exp_tk[i], (i < 0) ? 32'h2000 : exp_tg[i]});
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({lookup_hit, predict_taken, predict_target} !== {e.hit, e.tk, e.tg}) begin
        n_bad++;
        $display("FAIL counter step %0d got %b/%b/%h want %b/%b/%h", i, lookup_hit, predict_taken, predict_target, e.hit, e.tk, e.tg);
      end
      lookup_pc = IDLE_PC;
      @(negedge clk);
    end
  endtask

  task automatic test_miss_not_taken();
    lk_t e;
    lk_t chk [2];
    do_flush();
    upd(32'h1060, 32'h2060, 1'b0);
    chk[0] = {32'h1060, 1'b0, 1'b0, 32'h0};
    upd(32'h1000, 32'h2000, 1'b1);
    upd(32'h1060, 32'h2060, 1'b0);
    chk[1] = {32'h1000, 1'b1, 1'b1, 32'h2000};
    foreach (chk[i]) begin
      drive_lookup(chk[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({lookup_hit, predict_taken, predict_target} !== {e.hit, e.tk, e.tg}) begin
        n_bad++;
        $display("FAIL miss_nt pc=%h got %b/%b/%h want %b/%b/%h", e.pc, lookup_hit, predict_taken, predict_target, e.hit, e.tk, e.tg);
      end
      lookup_pc = IDLE_PC;
      @(negedge clk);
    end
  endtask

  task automatic test_fill();
    lk_t e;
    lk_t chk [6];
    chk = '{{32'h1000, 1'b0, 1'b0, 32'h0}, {32'h1020, 1'b1, 1'b1, 32'h2020},
            {32'h1040, 1'b1, 1'b1, 32'h2040}, {32'h1000, 1'b1, 1'b1, 32'h2000},
            {32'h1020, 1'b0, 1'b0, 32'h0},    {32'h1040, 1'b1, 1'b1, 32'h2040}};
    for (int pass = 0; pass < 2; pass++) begin
      do_flush();
      upd(32'h1000, 32'h2000, 1'b1);
      upd(32'h1020, 32'h2020, 1'b1);
      if (pass == 1) begin
        lookup_pc = 32'h1000;
        @(negedge clk);
        lookup_pc = IDLE_PC;
      end
      upd(32'h1040, 32'h2040, 1'b1);
      for (int i = 0; i < 3; i++) begin
        drive_lookup(chk[pass*3+i]);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({lookup_hit, predict_taken, predict_target} !== {e.hit, e.tk, e.tg}) begin
          n_bad++;
          $display("FAIL fill pass%0d pc=%h got %b/%b/%h want %b/%b/%h", pass, e.pc, lookup_hit, predict_taken, predict_target, e.hit, e.tk, e.tg);
        end
        lookup_pc = IDLE_PC;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_same_cycle();
    lk_t e;
    lk_t chk [6];
    chk = '{{32'h1000, 1'b1, 1'b1, 32'h2000}, {32'h1020, 1'b1, 1'b1, 32'h2020},
            {32'h1000, 1'b0, 1'b0, 32'h0},    {32'h1040, 1'b1, 1'b1, 32'h2040},
            {32'h1020, 1'b1, 1'b1, 32'h2020}, {32'h1020, 1'b1, 1'b1, 32'h7020}};
    do_flush();
    upd(32'h1000, 32'h2000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        update_valid = 1'b1; update_pc = 32'h1020; update_target = 32'h2020; update_taken = 1'b1;
      end
      if (i == 2) upd(32'h1040, 32'h2040, 1'b1);
      if (i == 4) begin
        update_valid = 1'b1; update_pc = 32'h1020; update_target = 32'h7020; update_taken = 1'b1;
      end
      drive_lookup(chk[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({lookup_hit, predict_taken, predict_target} !== {e.hit, e.tk, e.tg}) begin
        n_bad++;
        $display("FAIL same_cycle step %0d pc=%h got %b/%b/%h want %b/%b/%h", i, e.pc, lookup_hit, predict_taken, predict_target, e.hit, e.tk, e.tg);
      end
      @(negedge clk);
      update_valid = 1'b0;
      lookup_pc = IDLE_PC;
    end
  endtask

  task automatic test_flush_and_reset();
    lk_t e;
    lk_t chk [5];
    chk = '{{32'h3000, 1'b0, 1'b0, 32'h0}, {32'h1020, 1'b0, 1'b0, 32'h0},
            {32'h1040, 1'b0, 1'b0, 32'h0}, {32'h1000, 1'b0, 1'b0, 32'h0},
            {32'h1020, 1'b0, 1'b0, 32'h0}};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        flush = 1'b1;
        upd(32'h3000, 32'h4000, 1'b1);
        flush = 1'b0;
      end
      if (i == 3) begin
        upd(32'h1000, 32'h2000, 1'b1);
        rst_n = 1'b0;
        upd(32'h1020, 32'h2020, 1'b1);
        rst_n = 1'b1;
      end
      drive_lookup(chk[i]);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({lookup_hit, predict_taken, predict_target} !== {e.hit, e.tk, e.tg}) begin
        n_bad++;
        $display("FAIL flush_reset step %0d pc=%h got %b/%b/%h want %b/%b/%h", i, e.pc, lookup_hit, predict_taken, predict_target, e.hit, e.tk, e.tg);
      end
      lookup_pc = IDLE_PC;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    lk_t e;
    update_valid = 1'b1; update_taken = 1'b1;
    for (int k = 0; k < 8; k++) begin
      update_pc     = 32'h4000 + 32'(k * 4);
      update_target = 32'h8000 + 32'(k);
      @(negedge clk);
    end
    update_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_lookup({32'h4000 + 32'(k * 4), 1'b1, 1'b1, 32'h8000 + 32'(k)});
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({lookup_hit, predict_taken, predict_target} !== {e.hit, e.tk, e.tg}) begin
        n_bad++;
        $display("FAIL b2b set %0d got %b/%b/%h want %b/%b/%h", k, lookup_hit, predict_taken, predict_target, e.hit, e.tk, e.tg);
      end
      lookup_pc = IDLE_PC;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; lookup_pc = IDLE_PC;
    update_valid = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
    @(negedge clk);
    test_reset();
    test_counter();
    test_miss_not_taken();
    test_fill();
    test_same_cycle();
    test_flush_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
